// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: shift-add multiplier and restoring divider, one bit per cycle,
// with sign pre/post-correction and the RISC-V divide-by-zero / overflow results.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start with a valid M-extension alu_ctrl
// PREP   | record signs, take absolute values, detect special cases
// CALC   | XLEN iterations of shift-add or restoring subtract
// FIX    | sign fix-up and result select (or special result)
// DONE   | result valid, one-cycle done pulse
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [4:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_a, neg_b;
  logic [CW-1:0]     cnt;
  logic              special;
  logic [XLEN-1:0]   spec_res;

  logic              valid_op, is_mul, is_rem, signed_a, signed_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    valid_op = (alu_ctrl >= OP_MUL) && (alu_ctrl <= OP_REMU);
    is_mul   = (op_q <= OP_MULHU);
    is_rem   = (op_q == OP_REM) || (op_q == OP_REMU);
    signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    div_zero = !is_mul && (b_q == '0);
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == INT_MIN) && (b_q == '1);
    abs_a    = (signed_a && a_q[XLEN-1]) ? -a_q : a_q;
    abs_b    = (signed_b && b_q[XLEN-1]) ? -b_q : b_q;

    // multiplier lives in acc low half, product accumulates in the high half
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);

    // partial remainder needs one extra bit: shifted value can reach 2*divisor-1
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_sub  = rem_sh[XLEN-1:0] - b_q;

    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    fix_res = quo_fix;
    if (op_q == OP_MUL)   fix_res = prod_fix[XLEN-1:0];
    else if (is_mul)      fix_res = prod_fix[2*XLEN-1:XLEN];
    else if (is_rem)      fix_res = rem_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && valid_op && !flush) state_nxt = S_PREP;
        S_PREP:  state_nxt = (div_zero || div_ovf) ? S_FIX : S_CALC;
        S_CALC:  if (cnt == CW'(XLEN-1)) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      cnt      <= '0;
      special  <= 1'b0;
      spec_res <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (state_nxt == S_PREP) begin
            op_q <= alu_ctrl;
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        S_PREP: begin
          neg_a    <= signed_a && a_q[XLEN-1];
          neg_b    <= signed_b && b_q[XLEN-1];
          a_q      <= abs_a;
          b_q      <= abs_b;
          acc      <= {{XLEN{1'b0}}, abs_a};
          cnt      <= '0;
          special  <= div_zero || div_ovf;
          if (div_zero) spec_res <= is_rem ? a_q : '1;
          else          spec_res <= is_rem ? '0 : INT_MIN;
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_mul)      acc <= {mul_sum, acc[XLEN-1:1]};
          else if (rem_ge) acc <= {rem_sub, acc[XLEN-2:0], 1'b1};
          else             acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
        S_FIX: begin
          if (state_nxt == S_DONE) result <= special ? spec_res : fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, busy/done,
// special divide cases, flush, invalid opcodes and mid-operation reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    logic busy_ok, got;
    @(negedge clk);
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && cyc < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) got = 1'b1;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_result"}, result, exp_res);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {30'd0, busy, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    // special cases: done two cycles after accept
    run_op("div_by_zero",  5'b01111, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
    run_op("rem_by_zero",  5'b10001, 32'd5,        32'd0,        32'd5,        2);
    run_op("div_overflow", 5'b01111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem_overflow", 5'b10001, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

    run_op("mul",    5'b01011, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh",   5'b01100, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu",  5'b01110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu", 5'b01101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("div",    5'b01111, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",    5'b10001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu",   5'b10000, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
    run_op("remu",   5'b10010, 32'hFFFFFFF9, 32'd2,        32'd1,        34);

    // flush mid-DIVU: result keeps the REMU value of 1
    @(negedge clk);
    start = 1'b1; alu_ctrl = 5'b10000; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_done", {30'd0, busy, done}, 32'd0);
    check("flush_result", result, 32'd1);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("flush_quiet", seen_done, 0);
    run_op("mul_after_flush", 5'b01011, 32'd3, 32'd4, 32'd12, 34);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_ctrl = 5'b01011; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);

    // invalid opcode never accepted
    @(negedge clk);
    start = 1'b1; alu_ctrl = 5'b00000; op_a = 32'd9; op_b = 32'd9;
    seen_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy === 1'b1 || done === 1'b1) seen_done++;
    end
    start = 1'b0;
    check("invalid_op", seen_done, 0);
    check("invalid_op_result", result, 32'd12);

    // reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; alu_ctrl = 5'b01011; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_mul_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_mul_flags", {30'd0, busy, done}, 32'd0);
    check("reset_mid_mul_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul_after_reset", 5'b01011, 32'd5, 32'd6, 32'd30, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
